mips_prog_loader: RTL and testbench

- Synthesizable boot/run controller for the pipelined MIPS32 core.
- Initialises the register file and streams a program into instruction memory over a valid/ready handshake.
- Releases the core from PC=0, counts cycles until HALT or timeout, then reports status.
- Replaces per-bench hierarchical pokes into Reg/Mem/PC/HALTED with one parametrised, reusable block between the bench or host and the core.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/mips_run_timer.sv | 40 ++++
 rtl/mips_prog_loader.sv | 166 ++++++++++++++++
 tb/tb_mips_prog_loader.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS32 boot/run controller slice:
//   - default word and register-address widths
//   - loader FSM state encoding
//   - HLT opcode and register-init mode constants
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  // Primary opcode field (instr[31:26]) of the core's HALT instruction
  localparam logic [5:0] OP_HLT = 6'h3f;

  // reg_init_mode encodings
  localparam logic REG_INIT_ZERO  = 1'b0;
  localparam logic REG_INIT_IDENT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_REGS,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_TOUT
  } loader_state_e;

endpackage

// File: rtl/mips_run_timer.sv
// mips_run_timer
// Saturating run-phase cycle counter with terminal-count look-ahead.
// Ports:
//   clk1   - clock
//   rst_n  - synchronous active-low reset
//   clr    - synchronous clear (start of a new session)
//   en     - count this cycle (core running)
//   count  - registered cycles counted so far, saturates at MAX_CYCLES
//   last   - this enabled cycle brings count to MAX_CYCLES
module mips_run_timer #(
  parameter int MAX_CYCLES = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_CYCLES - 1);

  // Look-ahead so the controller can leave RUN on the same edge that
  // the count lands on MAX_CYCLES.
  assign last = en && (count >= MAX_M1);

  // Counter holds at MAX_CYCLES instead of wrapping.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count < MAX_C)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// mips_prog_loader
// Boot/run controller for the pipelined MIPS32 core. On start it clears or
// identity-initialises the register file, streams a program into
// instruction memory over a valid/ready handshake, releases the core and
// watches for HALT or a run-phase timeout.
// Ports:
//   clk1, rst_n                      - clock, synchronous active-low reset
//   start, reg_init_mode             - session start pulse, register init mode
//   prog_valid/ready/data/last       - program word stream
//   mem_we/addr/wdata                - instruction memory write port
//   reg_we/addr/wdata                - register file write port
//   cpu_run, cpu_halted              - core release / core HALTED flag
//   busy, done, timeout, overflow    - session status (done/timeout/overflow sticky)
//   prog_len, cycle_count            - words loaded, run cycles elapsed
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = 10,
  parameter int PROG_DEPTH = 1024,
  parameter int NUM_REGS   = 32,
  parameter int REG_AW     = REG_AW_DEF,
  parameter int MAX_CYCLES = 4096,
  parameter int CNT_W      = 16
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              reg_init_mode,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   prog_len,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [REG_AW-1:0] REG_LAST = REG_AW'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   LEN_LAST = (ADDR_W + 1)'(PROG_DEPTH - 1);

  loader_state_e     state;
  logic              mode_q;
  logic              accept;
  logic              idle_like;
  logic              run_clr;
  logic              run_en;
  logic              run_last;
  logic [REG_AW-1:0] reg_next;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_TOUT);
  assign run_clr   = idle_like && start;
  assign run_en    = (state == ST_RUN);
  assign reg_next  = reg_addr + 1'b1;

  // Handshake and memory write port are combinational so a word is written
  // in the cycle it is accepted. Gating with rst_n keeps a reset cycle from
  // ever producing a memory write.
  assign prog_ready = rst_n && (state == ST_LOAD);
  assign accept     = prog_ready && prog_valid;
  assign mem_we     = accept;
  assign mem_addr   = prog_len[ADDR_W-1:0];
  assign mem_wdata  = accept ? prog_data : '0;

  mips_run_timer #(
    .MAX_CYCLES(MAX_CYCLES),
    .CNT_W     (CNT_W)
  ) u_run_timer (
    .clk1 (clk1),
    .rst_n(rst_n),
    .clr  (run_clr),
    .en   (run_en),
    .count(cycle_count),
    .last (run_last)
  );

  // Session FSM with registered outputs. The register write port is
  // registered: reg 0 is presented on the cycle after start, so reg_we is
  // high exactly while the FSM sits in INIT_REGS.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= REG_INIT_ZERO;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      overflow  <= 1'b0;
      prog_len  <= '0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      cpu_run   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_TOUT: begin
          if (start) begin
            state     <= ST_INIT_REGS;
            mode_q    <= reg_init_mode;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
            prog_len  <= '0;
            reg_we    <= 1'b1;
            reg_addr  <= '0;
            reg_wdata <= '0;
          end
        end
        ST_INIT_REGS: begin
          if (reg_addr == REG_LAST) begin
            state     <= ST_LOAD;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
          end else begin
            reg_addr  <= reg_next;
            reg_wdata <= (mode_q == REG_INIT_IDENT) ? DATA_W'(reg_next) : '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            prog_len <= prog_len + 1'b1;
            // A final word that also fills the memory is a clean finish.
            if (prog_last) begin
              state   <= ST_RUN;
              cpu_run <= 1'b1;
            end else if (prog_len == LEN_LAST) begin
              state    <= ST_RUN;
              cpu_run  <= 1'b1;
              overflow <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Halt takes priority over a timeout landing on the same cycle.
          if (cpu_halted) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            cpu_run <= 1'b0;
          end else if (run_last) begin
            state   <= ST_TOUT;
            timeout <= 1'b1;
            busy    <= 1'b0;
            cpu_run <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader
// Self-checking bench for mips_prog_loader. A small fake core answers
// cpu_run with cpu_halted after a chosen number of run cycles; all write
// traffic is logged and compared against a session-level model.
module tb_mips_prog_loader;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 10;
  localparam int PROG_DEPTH = 16;
  localparam int NUM_REGS   = 32;
  localparam int REG_AW     = 5;
  localparam int MAX_CYCLES = 100;
  localparam int CNT_W      = 16;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              reg_init_mode = 1'b0;
  logic              prog_valid = 1'b0;
  logic              prog_last = 1'b0;
  logic              cpu_halted = 1'b0;
  logic [DATA_W-1:0] prog_data = '0;
  logic              prog_ready, mem_we, reg_we, cpu_run;
  logic              busy, done, timeout, overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, reg_wdata;
  logic [REG_AW-1:0] reg_addr;
  logic [ADDR_W:0]   prog_len;
  logic [CNT_W-1:0]  cycle_count;

  int tests_run = 0;
  int tests_failed = 0;

  int unsigned       mem_addr_q[$];
  logic [DATA_W-1:0] mem_data_q[$];
  int unsigned       reg_addr_q[$];
  logic [DATA_W-1:0] reg_data_q[$];
  logic [DATA_W-1:0] words[$];
  int                both_we = 0;

  mips_prog_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_DEPTH(PROG_DEPTH), .NUM_REGS(NUM_REGS),
    .REG_AW(REG_AW), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .reg_init_mode(reg_init_mode),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_data(prog_data),
    .prog_last(prog_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .cpu_run(cpu_run),
    .cpu_halted(cpu_halted), .busy(busy), .done(done), .timeout(timeout),
    .overflow(overflow), .prog_len(prog_len), .cycle_count(cycle_count)
  );

  always #5 clk1 = ~clk1;

  // Log every write that lands at a clock edge.
  always @(posedge clk1) begin
    if (mem_we === 1'b1) begin
      mem_addr_q.push_back(int'(mem_addr));
      mem_data_q.push_back(mem_wdata);
    end
    if (reg_we === 1'b1) begin
      reg_addr_q.push_back(int'(reg_addr));
      reg_data_q.push_back(reg_wdata);
    end
    if (mem_we === 1'b1 && reg_we === 1'b1) both_we++;
  end

  // Session model: words written, overflow, and run outcome.
  function automatic int model_accepted(input int n);
    return (n < PROG_DEPTH) ? n : PROG_DEPTH;
  endfunction

  function automatic bit model_overflow(input int n, input bit use_last);
    return !(use_last && n <= PROG_DEPTH) && (n >= PROG_DEPTH);
  endfunction

  function automatic bit model_done(input int halt_at);
    return (halt_at != 0) && (halt_at <= MAX_CYCLES);
  endfunction

  function automatic int model_cycles(input int halt_at);
    return model_done(halt_at) ? halt_at : MAX_CYCLES;
  endfunction

  task automatic clear_logs();
    mem_addr_q.delete();
    mem_data_q.delete();
    reg_addr_q.delete();
    reg_data_q.delete();
  endtask

  task automatic pulse_start(input bit mode);
    @(negedge clk1);
    reg_init_mode = mode;
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
  endtask

  // pattern 0: random gaps, 1: valid toggles every cycle, 2: always valid
  task automatic drive_prog(input int n, input bit use_last, input int pattern, output int accepted);
    int guard;
    bit phase;
    bit acc;
    accepted = 0;
    guard = 0;
    phase = 1'b0;
    while (accepted < n && guard < 400) begin
      @(negedge clk1);
      guard++;
      case (pattern)
        0: prog_valid = ($urandom_range(0, 2) != 0);
        1: begin prog_valid = phase; phase = ~phase; end
        default: prog_valid = 1'b1;
      endcase
      prog_data = words[accepted];
      prog_last = use_last && (accepted == n - 1);
      #1;
      if (accepted > 0 && !prog_ready) break;
      acc = prog_valid && prog_ready;
      @(posedge clk1);
      if (acc) accepted++;
    end
    #1;
    prog_valid = 1'b0;
    prog_last = 1'b0;
    tests_run++;
    if (guard >= 400) begin
      tests_failed++;
      $display("[TB] FAIL load_budget: accepted %0d of %0d words in %0d cycles", accepted, n, guard);
    end
  endtask

  // Fake core: asserts cpu_halted during its halt_at-th run cycle (0 = never).
  task automatic run_core(input int halt_at, output int seen);
    int guard;
    bit started;
    seen = 0;
    guard = 0;
    started = 1'b0;
    while (guard < 1000) begin
      @(negedge clk1);
      guard++;
      cpu_halted = 1'b0;
      if (cpu_run === 1'b1) begin
        started = 1'b1;
        seen++;
        if (seen == halt_at) cpu_halted = 1'b1;
      end else if (started) begin
        break;
      end
    end
    cpu_halted = 1'b0;
    tests_run++;
    if (!started || guard >= 1000) begin
      tests_failed++;
      $display("[TB] FAIL run_budget: started=%0d run cycles seen %0d after %0d cycles", started, seen, guard);
    end
  endtask

  task automatic test_reset();
    int acc, seen;
    rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    tests_run++;
    if (busy !== 1'b0 || prog_len !== '0 || cycle_count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counters: busy=%b prog_len=%0d cycle_count=%0d, need all 0", busy, prog_len, cycle_count);
    end
    tests_run++;
    if ({done, timeout, overflow, cpu_run, reg_we, mem_we, prog_ready} !== 7'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: {done,timeout,overflow,cpu_run,reg_we,mem_we,prog_ready}=%b, need 0000000",
               {done, timeout, overflow, cpu_run, reg_we, mem_we, prog_ready});
    end
    @(negedge clk1);
    rst_n = 1'b1;

    clear_logs();
    words = '{$urandom(), $urandom(), $urandom()};
    pulse_start(1'b0);
    drive_prog(3, 1'b0, 2, acc);
    tests_run++;
    if (mem_addr_q.size() != 3) begin
      tests_failed++;
      $display("[TB] FAIL preload_writes: got %0d writes, need 3", mem_addr_q.size());
    end
    @(negedge clk1);
    prog_valid = 1'b1;
    prog_data = $urandom();
    rst_n = 1'b0;
    @(negedge clk1);
    tests_run++;
    if (busy !== 1'b0 || prog_len !== '0 || mem_we !== 1'b0 || prog_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midload_reset: busy=%b prog_len=%0d mem_we=%b prog_ready=%b, need 0 0 0 0",
               busy, prog_len, mem_we, prog_ready);
    end
    rst_n = 1'b1;
    prog_valid = 1'b0;

    clear_logs();
    words = '{32'hfc000000};
    pulse_start(1'b1);
    repeat (3) @(negedge clk1);
    tests_run++;
    if (reg_addr_q.size() < 2 || reg_addr_q[0] != 0 || reg_data_q[1] !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL restart_reg0: %0d reg writes, first addr %0d, need first addr 0 then data 1",
               reg_addr_q.size(), (reg_addr_q.size() > 0) ? reg_addr_q[0] : 99);
    end
    drive_prog(1, 1'b1, 2, acc);
    run_core(2, seen);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL restart_done: done=%b, need 1", done);
    end
  endtask

  task automatic test_load_run();
    int acc, seen, halt_at, bad;
    words = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
              32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    halt_at = int'($urandom_range(5, 60));
    clear_logs();
    pulse_start(1'b1);
    drive_prog(9, 1'b1, 1, acc);
    run_core(halt_at, seen);
    bad = 0;
    for (int k = 0; k < reg_addr_q.size(); k++)
      if (reg_addr_q[k] != k || reg_data_q[k] !== DATA_W'(k)) bad++;
    tests_run++;
    if (reg_addr_q.size() != NUM_REGS || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL ident_regs: %0d reg writes with %0d wrong, need %0d writes Reg[k]=k", reg_addr_q.size(), bad, NUM_REGS);
    end
    bad = 0;
    for (int k = 0; k < mem_addr_q.size(); k++)
      if (mem_addr_q[k] != k || k >= 9 || mem_data_q[k] !== words[k]) bad++;
    tests_run++;
    if (mem_addr_q.size() != 9 || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL toggled_load: %0d mem writes with %0d wrong, need 9 at addr 0..8", mem_addr_q.size(), bad);
    end
    tests_run++;
    if (prog_len !== 9 || done !== 1'b1 || timeout !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_run_status: prog_len=%0d done=%b timeout=%b overflow=%b busy=%b, need 9 1 0 0 0",
               prog_len, done, timeout, overflow, busy);
    end
    tests_run++;
    if (cycle_count !== model_cycles(halt_at) || seen != model_cycles(halt_at)) begin
      tests_failed++;
      $display("[TB] FAIL load_run_cycles: cycle_count=%0d run window=%0d, need %0d", cycle_count, seen, model_cycles(halt_at));
    end
  endtask

  task automatic test_random_prog();
    int n, acc, seen, halt_at, bad;
    bit mode;
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(1, PROG_DEPTH));
      mode = 1'($urandom_range(0, 1));
      halt_at = int'($urandom_range(1, MAX_CYCLES - 1));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom());
      clear_logs();
      pulse_start(mode);
      drive_prog(n, 1'b1, 0, acc);
      run_core(halt_at, seen);
      bad = 0;
      for (int k = 0; k < reg_data_q.size(); k++)
        if (reg_data_q[k] !== (mode ? DATA_W'(k) : '0)) bad++;
      tests_run++;
      if (reg_data_q.size() != NUM_REGS || bad != 0) begin
        tests_failed++;
        $display("[TB] FAIL rand_regs[%0d]: mode %0d, %0d writes with %0d wrong", it, mode, reg_data_q.size(), bad);
      end
      bad = 0;
      for (int k = 0; k < mem_addr_q.size(); k++)
        if (k >= n || mem_addr_q[k] != k || mem_data_q[k] !== words[k]) bad++;
      tests_run++;
      if (mem_addr_q.size() != model_accepted(n) || bad != 0 || prog_len !== model_accepted(n)) begin
        tests_failed++;
        $display("[TB] FAIL rand_image[%0d]: %0d writes (%0d wrong) prog_len=%0d, need %0d", it, mem_addr_q.size(), bad, prog_len, n);
      end
      tests_run++;
      if (done !== 1'b1 || timeout !== 1'b0 || cycle_count !== model_cycles(halt_at)) begin
        tests_failed++;
        $display("[TB] FAIL rand_run[%0d]: done=%b timeout=%b cycle_count=%0d, need 1 0 %0d", it, done, timeout, cycle_count, halt_at);
      end
    end
  endtask

  task automatic test_overflow();
    int acc, seen, bad;
    words.delete();
    for (int i = 0; i < PROG_DEPTH + 4; i++) words.push_back($urandom());
    clear_logs();
    pulse_start(1'b0);
    drive_prog(PROG_DEPTH + 4, 1'b0, 2, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk1);
      prog_valid = 1'b1;
      #1;
      tests_run++;
      if (prog_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ovf_ready: prog_ready=%b after overflow, need 0", prog_ready);
      end
    end
    @(negedge clk1);
    prog_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < mem_addr_q.size(); k++)
      if (mem_addr_q[k] != k || mem_data_q[k] !== words[k]) bad++;
    tests_run++;
    if (mem_addr_q.size() != model_accepted(PROG_DEPTH + 4) || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL ovf_writes: %0d writes (%0d wrong), need %0d", mem_addr_q.size(), bad, PROG_DEPTH);
    end
    tests_run++;
    if (overflow !== model_overflow(PROG_DEPTH + 4, 1'b0) || prog_len !== PROG_DEPTH) begin
      tests_failed++;
      $display("[TB] FAIL ovf_status: overflow=%b prog_len=%0d, need 1 %0d", overflow, prog_len, PROG_DEPTH);
    end
    run_core(4, seen);
    tests_run++;
    if (done !== 1'b1 || overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ovf_done: done=%b overflow=%b, need 1 1", done, overflow);
    end
  endtask

  task automatic test_depth_boundary();
    int acc, seen;
    words.delete();
    for (int i = 0; i < PROG_DEPTH; i++) words.push_back($urandom());
    clear_logs();
    pulse_start(1'b1);
    drive_prog(PROG_DEPTH, 1'b1, 0, acc);
    run_core(7, seen);
    tests_run++;
    if (overflow !== model_overflow(PROG_DEPTH, 1'b1) || prog_len !== PROG_DEPTH || mem_addr_q.size() != PROG_DEPTH) begin
      tests_failed++;
      $display("[TB] FAIL full_with_last: overflow=%b prog_len=%0d writes=%0d, need 0 %0d %0d",
               overflow, prog_len, mem_addr_q.size(), PROG_DEPTH, PROG_DEPTH);
    end
    tests_run++;
    if (mem_addr_q.size() > 0 && (mem_addr_q[PROG_DEPTH-1] != PROG_DEPTH - 1 || mem_data_q[PROG_DEPTH-1] !== words[PROG_DEPTH-1])) begin
      tests_failed++;
      $display("[TB] FAIL last_slot: addr %0d data %h, need addr %0d data %h",
               mem_addr_q[PROG_DEPTH-1], mem_data_q[PROG_DEPTH-1], PROG_DEPTH - 1, words[PROG_DEPTH-1]);
    end
  endtask

  task automatic test_timeout();
    int acc, seen;
    words = '{32'h0c000000, 32'h3c00fffe};
    clear_logs();
    pulse_start(1'b0);
    drive_prog(2, 1'b1, 2, acc);
    run_core(0, seen);
    tests_run++;
    if (timeout !== 1'b1 || done !== 1'b0 || cpu_run !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL tout_status: timeout=%b done=%b cpu_run=%b busy=%b, need 1 0 0 0", timeout, done, cpu_run, busy);
    end
    tests_run++;
    if (cycle_count !== model_cycles(0) || seen != model_cycles(0)) begin
      tests_failed++;
      $display("[TB] FAIL tout_cycles: cycle_count=%0d run window=%0d, need %0d", cycle_count, seen, MAX_CYCLES);
    end
    repeat (3) @(negedge clk1);
    tests_run++;
    if (cycle_count !== MAX_CYCLES || timeout !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL tout_hold: cycle_count=%0d timeout=%b, need %0d 1", cycle_count, timeout, MAX_CYCLES);
    end
  endtask

  task automatic test_tie_and_busy_start();
    int acc, seen, bad;
    words = '{$urandom(), $urandom(), 32'hfc000000};
    clear_logs();
    pulse_start(1'b0);
    tests_run++;
    if (timeout !== 1'b0 || cycle_count !== '0 || prog_len !== '0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL restart_clear: timeout=%b cycle_count=%0d prog_len=%0d busy=%b, need 0 0 0 1",
               timeout, cycle_count, prog_len, busy);
    end
    repeat (5) @(negedge clk1);
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    drive_prog(3, 1'b1, 2, acc);
    run_core(MAX_CYCLES, seen);
    bad = 0;
    for (int k = 0; k < reg_addr_q.size(); k++)
      if (reg_addr_q[k] != k) bad++;
    tests_run++;
    if (reg_addr_q.size() != NUM_REGS || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL busy_start: %0d reg writes (%0d out of order), need %0d", reg_addr_q.size(), bad, NUM_REGS);
    end
    tests_run++;
    if (done !== model_done(MAX_CYCLES) || timeout !== 1'b0 || cycle_count !== model_cycles(MAX_CYCLES)) begin
      tests_failed++;
      $display("[TB] FAIL halt_at_limit: done=%b timeout=%b cycle_count=%0d, need 1 0 %0d", done, timeout, cycle_count, MAX_CYCLES);
    end
    tests_run++;
    if (both_we != 0) begin
      tests_failed++;
      $display("[TB] FAIL write_exclusive: %0d cycles with mem_we and reg_we both high, need 0", both_we);
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_random_prog();
    test_overflow();
    test_depth_boundary();
    test_timeout();
    test_tie_and_busy_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
